// File: rtl/store_commit_buffer_pkg.sv
// Shared definitions for the store commit buffer: subtype codes, tag constants, drain FSM states.
package store_commit_buffer_pkg;
  localparam int SCB_ROB_W = 6;

  localparam logic [2:0] SUB_SB = 3'b000;
  localparam logic [2:0] SUB_SH = 3'b001;
  localparam logic [2:0] SUB_SW = 3'b010;

  localparam logic [6:0]           STORE_OPCODE = 7'b0100011;
  localparam logic [SCB_ROB_W-1:0] INVALID_ROB  = 6'b010000;

  typedef enum logic {
    DRAIN_IDLE,
    DRAIN_REQ
  } drain_state_t;
endpackage

// File: rtl/store_commit_buffer_lane_align.sv
// Combinational byte-lane formatter: subtype and low address bits -> byte enables,
// lane-replicated write data and a misalignment/invalid-subtype fault flag.
module store_lane_align
  import store_commit_buffer_pkg::*;
(
  input  logic [2:0]  subtype,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        fault
);

  always_comb begin
    be    = 4'b0000;
    wdata = 32'h0;
    fault = 1'b0;
    case (subtype)
      SUB_SB: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{data[7:0]}};
      end
      SUB_SH: begin
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{data[15:0]}};
        fault = addr_lo[0];
      end
      SUB_SW: begin
        be    = 4'b1111;
        wdata = data;
        fault = |addr_lo;
      end
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_commit_buffer.sv
// In-order store buffer: accepts stores from the RS, broadcasts acceptance, waits for ROB commit,
// then drains committed stores to memory over req/ack. Flush discards the uncommitted tail.
module store_commit_buffer
  import store_commit_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ROB_W = SCB_ROB_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             store_enable,
  input  logic [ROB_W-1:0] store_robnum,
  input  logic [31:0]      store_data,
  input  logic [31:0]      store_addr,
  input  logic [2:0]       store_subtype,
  output logic             store_ready,
  input  logic             commit_valid,
  input  logic [ROB_W-1:0] commit_robnum,
  input  logic             flush,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_be,
  input  logic             mem_ack,
  output logic             cast,
  output logic [ROB_W-1:0] cast_robnum,
  output logic [31:0]      cast_data,
  output logic             cast_fault,
  output logic             overflow_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0] ent_valid, ent_committed, ent_fault;
  logic [ROB_W-1:0] ent_robnum  [DEPTH];
  logic [31:0]      ent_data    [DEPTH];
  logic [31:0]      ent_addr    [DEPTH];
  logic [2:0]       ent_subtype [DEPTH];

  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  drain_state_t  state;

  logic [DEPTH-1:0] commit_hit, committed_next;
  logic [CW-1:0]    n_committed;
  logic             enq, pop, start_req, head_ready, head_fault;
  logic [3:0]       enq_be, head_be;
  logic [31:0]      enq_wdata, head_wdata;
  logic             enq_fault, head_lane_fault;
  logic             unused_lane;

  assign store_ready = (count < CW'(DEPTH));
  // A flush in the same cycle wins over a new store.
  assign enq         = store_enable && store_ready && !flush;

  always_comb begin
    commit_hit  = '0;
    n_committed = '0;
    for (int i = 0; i < DEPTH; i++) begin
      commit_hit[i] = commit_valid && ent_valid[i] && (ent_robnum[i] == commit_robnum);
    end
    committed_next = ent_committed | commit_hit;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && committed_next[i]) n_committed = n_committed + CW'(1);
    end
  end

  // Using committed_next lets a commit arriving this cycle start the drain immediately.
  assign head_ready = ent_valid[head] && committed_next[head];
  assign head_fault = ent_fault[head];
  assign start_req  = (state == DRAIN_IDLE) && head_ready && !head_fault;
  assign pop        = ((state == DRAIN_IDLE) && head_ready && head_fault) ||
                      ((state == DRAIN_REQ) && mem_ack);

  store_lane_align u_enq_align (
    .subtype (store_subtype),
    .addr_lo (store_addr[1:0]),
    .data    (store_data),
    .be      (enq_be),
    .wdata   (enq_wdata),
    .fault   (enq_fault)
  );

  store_lane_align u_head_align (
    .subtype (ent_subtype[head]),
    .addr_lo (ent_addr[head][1:0]),
    .data    (ent_data[head]),
    .be      (head_be),
    .wdata   (head_wdata),
    .fault   (head_lane_fault)
  );

  assign unused_lane = ^{enq_be, enq_wdata, head_lane_fault};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ent_valid     <= '0;
      ent_committed <= '0;
      ent_fault     <= '0;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      overflow_err  <= 1'b0;
    end else begin
      ent_committed <= committed_next;
      if (store_enable && !store_ready) overflow_err <= 1'b1;

      if (flush) begin
        // Committed entries are contiguous from head, so the survivors end at head + n_committed.
        ent_valid <= ent_valid & committed_next;
        tail      <= head + n_committed[PW-1:0];
        count     <= n_committed - CW'(pop);
      end else begin
        count <= count + CW'(enq) - CW'(pop);
      end

      if (pop) begin
        ent_valid[head] <= 1'b0;
        head            <= head + PW'(1);
      end

      if (enq) begin
        ent_valid[tail]     <= 1'b1;
        ent_committed[tail] <= 1'b0;
        ent_fault[tail]     <= enq_fault;
        tail                <= tail + PW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (enq) begin
      ent_robnum[tail]  <= store_robnum;
      ent_data[tail]    <= store_data;
      ent_addr[tail]    <= store_addr;
      ent_subtype[tail] <= store_subtype;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cast        <= 1'b0;
      cast_robnum <= ROB_W'(INVALID_ROB);
      cast_data   <= 32'h0;
      cast_fault  <= 1'b0;
    end else begin
      cast        <= enq;
      cast_robnum <= enq ? store_robnum : ROB_W'(INVALID_ROB);
      cast_data   <= enq ? store_addr : 32'h0;
      cast_fault  <= enq ? enq_fault : 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= DRAIN_IDLE;
      mem_req   <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_be    <= 4'b0000;
    end else begin
      case (state)
        DRAIN_IDLE: begin
          if (start_req) begin
            state     <= DRAIN_REQ;
            mem_req   <= 1'b1;
            mem_addr  <= {ent_addr[head][31:2], 2'b00};
            mem_wdata <= head_wdata;
            mem_be    <= head_be;
          end
        end
        DRAIN_REQ: begin
          if (mem_ack) begin
            state     <= DRAIN_IDLE;
            mem_req   <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_be    <= 4'b0000;
          end
        end
        default: state <= DRAIN_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_commit_buffer.sv
// Directed self-checking bench for store_commit_buffer.
module tb_store_commit_buffer;
  logic        clock = 1'b0;
  logic        reset;
  logic        store_enable;
  logic [5:0]  store_robnum;
  logic [31:0] store_data, store_addr;
  logic [2:0]  store_subtype;
  logic        store_ready;
  logic        commit_valid;
  logic [5:0]  commit_robnum;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        cast;
  logic [5:0]  cast_robnum;
  logic [31:0] cast_data;
  logic        cast_fault;
  logic        overflow_err;

  int n_checks = 0;
  int n_fail   = 0;

  store_commit_buffer #(.DEPTH(4), .ROB_W(6)) dut (
    .clock(clock), .reset(reset),
    .store_enable(store_enable), .store_robnum(store_robnum), .store_data(store_data),
    .store_addr(store_addr), .store_subtype(store_subtype), .store_ready(store_ready),
    .commit_valid(commit_valid), .commit_robnum(commit_robnum), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .cast(cast), .cast_robnum(cast_robnum), .cast_data(cast_data),
    .cast_fault(cast_fault), .overflow_err(overflow_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [5:0] tag, input logic [31:0] d, input logic [31:0] a,
                      input logic [2:0] st);
    store_enable  = 1'b1;
    store_robnum  = tag;
    store_data    = d;
    store_addr    = a;
    store_subtype = st;
    tick();
    store_enable  = 1'b0;
  endtask

  task automatic commit_tag(input logic [5:0] tag);
    commit_valid  = 1'b1;
    commit_robnum = tag;
    tick();
    commit_valid  = 1'b0;
  endtask

  task automatic ack_once();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if (store_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", store_ready); end
    n_checks++; if (cast !== 1'b0) begin n_fail++; $display("FAIL reset_cast got %b want 0", cast); end
    n_checks++; if (cast_robnum !== 6'b010000) begin n_fail++; $display("FAIL reset_cast_robnum got %b want 010000", cast_robnum); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
    n_checks++; if (mem_be !== 4'b0000) begin n_fail++; $display("FAIL reset_mem_be got %b want 0000", mem_be); end
    n_checks++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow_err); end
  endtask

  task automatic test_sw();
    push(6'd3, 32'hDEADBEEF, 32'h100, 3'b010);
    n_checks++; if (cast !== 1'b1) begin n_fail++; $display("FAIL sw_cast got %b want 1", cast); end
    n_checks++; if (cast_robnum !== 6'd3) begin n_fail++; $display("FAIL sw_cast_robnum got %0d want 3", cast_robnum); end
    n_checks++; if (cast_fault !== 1'b0) begin n_fail++; $display("FAIL sw_cast_fault got %b want 0", cast_fault); end
    n_checks++; if (cast_data !== 32'h100) begin n_fail++; $display("FAIL sw_cast_data got %h want 00000100", cast_data); end
    tick();
    n_checks++; if (cast !== 1'b0 || cast_robnum !== 6'b010000) begin n_fail++; $display("FAIL sw_cast_idle got %b/%b want 0/010000", cast, cast_robnum); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL sw_no_req_before_commit got %b want 0", mem_req); end
    commit_tag(6'd3);
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL sw_mem_req got %b want 1", mem_req); end
    n_checks++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL sw_mem_addr got %h want 00000100", mem_addr); end
    n_checks++; if (mem_be !== 4'b1111) begin n_fail++; $display("FAIL sw_mem_be got %b want 1111", mem_be); end
    n_checks++; if (mem_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_mem_wdata got %h want deadbeef", mem_wdata); end
    repeat (3) tick();
    n_checks++; if (mem_req !== 1'b1 || mem_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_hold got %b/%h want 1/deadbeef", mem_req, mem_wdata); end
    ack_once();
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL sw_after_ack got %b want 0", mem_req); end
  endtask

  task automatic test_sb_sh();
    push(6'd4, 32'h000000AB, 32'h203, 3'b000);
    push(6'd6, 32'h00001234, 32'h202, 3'b001);
    commit_tag(6'd4);
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL sb_mem_req got %b want 1", mem_req); end
    n_checks++; if (mem_addr !== 32'h200) begin n_fail++; $display("FAIL sb_mem_addr got %h want 00000200", mem_addr); end
    n_checks++; if (mem_be !== 4'b1000) begin n_fail++; $display("FAIL sb_mem_be got %b want 1000", mem_be); end
    n_checks++; if (mem_wdata !== 32'hABABABAB) begin n_fail++; $display("FAIL sb_mem_wdata got %h want abababab", mem_wdata); end
    commit_tag(6'd6);
    n_checks++; if (mem_be !== 4'b1000) begin n_fail++; $display("FAIL sb_hold_be got %b want 1000", mem_be); end
    ack_once();
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL sb_gap got %b want 0", mem_req); end
    tick();
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL sh_mem_req got %b want 1", mem_req); end
    n_checks++; if (mem_be !== 4'b1100) begin n_fail++; $display("FAIL sh_mem_be got %b want 1100", mem_be); end
    n_checks++; if (mem_wdata !== 32'h12341234) begin n_fail++; $display("FAIL sh_mem_wdata got %h want 12341234", mem_wdata); end
    n_checks++; if (mem_addr !== 32'h200) begin n_fail++; $display("FAIL sh_mem_addr got %h want 00000200", mem_addr); end
    ack_once();
  endtask

  task automatic test_fault();
    push(6'd5, 32'h55, 32'h102, 3'b010);
    n_checks++; if (cast_fault !== 1'b1) begin n_fail++; $display("FAIL fault_sw_cast got %b want 1", cast_fault); end
    commit_tag(6'd5);
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL fault_sw_no_req got %b want 0", mem_req); end
    push(6'd7, 32'h0, 32'h300, 3'b011);
    n_checks++; if (cast_fault !== 1'b1) begin n_fail++; $display("FAIL fault_subtype_cast got %b want 1", cast_fault); end
    push(6'd8, 32'h0, 32'h301, 3'b001);
    n_checks++; if (cast_fault !== 1'b1) begin n_fail++; $display("FAIL fault_sh_cast got %b want 1", cast_fault); end
    commit_tag(6'd7);
    commit_tag(6'd8);
    tick();
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL fault_no_req got %b want 0", mem_req); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) begin
      push(6'(10 + i), 32'(i), 32'h400 + 32'(4 * i), 3'b010);
      n_checks++;
      if (store_ready !== (i < 3)) begin n_fail++; $display("FAIL fill_ready_%0d got %b want %b", i, store_ready, (i < 3)); end
    end
    push(6'd14, 32'h0, 32'h500, 3'b010);
    n_checks++; if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL overflow_err got %b want 1", overflow_err); end
    n_checks++; if (cast !== 1'b0) begin n_fail++; $display("FAIL overflow_no_cast got %b want 0", cast); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++; if (store_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready got %b want 1", store_ready); end
    n_checks++; if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL overflow_sticky got %b want 1", overflow_err); end
  endtask

  task automatic test_commit_flush();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL overflow_cleared got %b want 0", overflow_err); end
    push(6'd1, 32'h11, 32'h10, 3'b010);
    push(6'd2, 32'h22, 32'h14, 3'b010);
    push(6'd3, 32'h33, 32'h18, 3'b010);
    commit_valid  = 1'b1;
    commit_robnum = 6'd1;
    flush         = 1'b1;
    tick();
    commit_valid  = 1'b0;
    flush         = 1'b0;
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin n_fail++; $display("FAIL cf_req got %b/%h want 1/00000010", mem_req, mem_addr); end
    n_checks++; if (mem_wdata !== 32'h11) begin n_fail++; $display("FAIL cf_wdata got %h want 00000011", mem_wdata); end
    ack_once();
    repeat (3) tick();
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL cf_no_more_req got %b want 0", mem_req); end
    for (int i = 0; i < 4; i++) begin
      push(6'(20 + i), 32'h0, 32'h600, 3'b010);
      n_checks++;
      if (store_ready !== (i < 3)) begin n_fail++; $display("FAIL cf_count_%0d got %b want %b", i, store_ready, (i < 3)); end
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset_mid();
    push(6'd9, 32'hCAFEF00D, 32'h500, 3'b010);
    commit_tag(6'd9);
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rm_req_up got %b want 1", mem_req); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rm_req_drop got %b want 0", mem_req); end
    n_checks++; if (store_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready got %b want 1", store_ready); end
    n_checks++; if (cast_robnum !== 6'b010000) begin n_fail++; $display("FAIL rm_cast_robnum got %b want 010000", cast_robnum); end
    tick();
    reset = 1'b0;
    repeat (3) tick();
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rm_entry_lost got %b want 0", mem_req); end
  endtask

  initial begin
    reset = 1'b1;
    store_enable = 1'b0; store_robnum = '0; store_data = '0; store_addr = '0; store_subtype = '0;
    commit_valid = 1'b0; commit_robnum = '0; flush = 1'b0; mem_ack = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    test_reset();
    test_sw();
    test_sb_sh();
    test_fault();
    test_overflow();
    test_commit_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/store_commit_buffer.md
# store_commit_buffer

Receives completed store operations (value, effective address, ROB tag, width) from the store reservation station and holds them in order until the reorder buffer commits them. Committed stores then drain to data memory through a req/ack handshake with byte-lane formatting. Acceptance of each store is broadcast on a CDB-style port so the ROB can mark the store ready to commit. Speculative (uncommitted) entries are discarded on flush.

## Interface
- DEPTH, 4, number of buffer entries (power of two)
- ROB_W, 6, ROB tag width
- clock  in  1  system clock, all state on posedge
- reset  in  1  asynchronous, active-high
- store_enable  in  1  one-cycle store request from the RS
- store_robnum  in  ROB_W  ROB tag of the store
- store_data  in  32  value to store (low bytes used for SB/SH)
- store_addr  in  32  effective address (base + offset, already added)
- store_subtype  in  3  000 SB, 001 SH, 010 SW; others invalid
- store_ready  out  1  buffer not full; RS must not assert store_enable when low
- commit_valid  in  1  ROB commits a store this cycle
- commit_robnum  in  ROB_W  tag being committed
- flush  in  1  discard all uncommitted entries
- mem_req  out  1  memory write request
- mem_addr  out  32  word address (store_addr with [1:0] cleared)
- mem_wdata  out  32  lane-replicated write data
- mem_be  out  4  byte enables
- mem_ack  in  1  memory accepted the write
- cast  out  1  one-cycle completion broadcast
- cast_robnum  out  ROB_W  tag of accepted store
- cast_data  out  32  effective address of accepted store
- cast_fault  out  1  store is misaligned or has invalid subtype
- overflow_err  out  1  sticky: store_enable seen while full

## Operation
- Circular FIFO: head/tail pointers, count 0..DEPTH; entry = {valid, committed, fault, robnum, data, addr, subtype}.
- Enqueue: store_enable && count<DEPTH (state at start of cycle) writes at tail. Full: request dropped, overflow_err set until reset.
- Fault: SH with addr[0]=1, SW with addr[1:0]!=0, subtype >010.
- Broadcast: cycle after enqueue, cast=1 with tag, addr, fault; otherwise cast=0, cast_robnum=6'b010000.
- Commit: sets committed on the valid entry whose robnum matches commit_robnum; no match is ignored.
- Flush: tail moves to head + number of committed entries (committed entries are contiguous from head); in-flight request continues. Flush with enqueue same cycle: enqueue dropped. Commit and flush same cycle: commit applied first.
- Drain FSM: IDLE -> REQ when head valid and committed and not fault; REQ holds mem_req, mem_addr, mem_wdata, mem_be stable until mem_ack high, then head pops, -> IDLE. Committed faulted head pops in IDLE without a request.
- Lanes: SB be=4'b0001<<addr[1:0], wdata={4{data[7:0]}}; SH be=addr[1]?1100:0011, wdata={2{data[15:0]}}; SW be=1111, wdata=data.

## Timing
- Reset: all outputs 0 except store_ready=1, cast_robnum=6'b010000; FIFO empty, FSM IDLE.
- Reset mid-request: mem_req drops immediately; entry lost.
- store_ready is combinational on count; dequeue in a cycle does not free a slot for the same cycle's enqueue.
- Accept-to-cast latency 1 cycle; commit-to-mem_req min 1 cycle; max drain rate 1 store per 2 cycles.
- mem_ack with mem_req low is ignored.

## Structure
- Shared package: subtype codes SB/SH/SW, store opcode 7'b0100011, INVALID_ROB 6'b010000, ROB_W.
- Sub-module store_lane_align: combinational subtype+addr+data -> be, wdata, fault; used at enqueue for fault and in REQ for outputs.

## Test plan
- SW data 0xDEADBEEF addr 0x100 tag 3 -> cast next cycle tag 3, fault 0; commit 3 -> mem_req addr 0x100, be 1111, wdata 0xDEADBEEF held until ack.
- SB data 0x000000AB addr 0x203 -> be 1000, wdata 0xABABABAB; SH addr 0x202 -> be 1100.
- SW addr 0x102 tag 5 -> cast_fault 1; commit 5 -> popped with no mem_req.
- Fill 4 stores -> store_ready 0; fifth store_enable -> dropped, overflow_err 1.
- Tags 1,2,3 queued, commit 1 and flush same cycle -> only tag 1 written, count ends 0.
- Reset asserted while mem_req high waiting for ack -> mem_req 0, store_ready 1, cast_robnum 6'b010000.
